// File: rtl/entropy_prng.sv
// entropy_prng: folds a Galois LFSR, stirred by the pool's e_bit stream, into random words.
// Define ENTROPY_PRNG_HEALTH_EN to enable the repetition-count health test.
module entropy_prng #(
  parameter int                 STATE_W    = 32,
  parameter int                 WB_WIDTH   = 32,
  parameter logic [STATE_W-1:0] TAPS       = STATE_W'(32'h80200003),
  parameter logic [STATE_W-1:0] SEED       = STATE_W'(32'h00000001),
  parameter int                 MIX_CYCLES = 4,
  parameter int                 REP_LIMIT  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                e_bit,
  input  logic                rnd_ready,
  output logic                rnd_valid,
  output logic [WB_WIDTH-1:0] rnd_word,
  output logic                health_fail
);

  localparam int CW = $clog2(MIX_CYCLES) + 1;

  typedef enum logic {
    MIX,
    HOLD
  } fsm_t;

  if (SEED == '0 || MIX_CYCLES < 1 || REP_LIMIT < 2 ||
      STATE_W < WB_WIDTH || STATE_W > 2 * WB_WIDTH) begin : g_bad_cfg
    $error("entropy_prng: illegal parameter set");
  end

  logic [STATE_W-1:0]    state;
  logic [STATE_W-1:0]    nxt;
  logic [STATE_W-1:0]    mix;
  logic [STATE_W-1:0]    state_d;
  logic [2*WB_WIDTH-1:0] ext;
  logic [WB_WIDTH-1:0]   fold_d;
  logic [CW-1:0]         cnt;
  fsm_t                  fsm;

  // Galois step stirred with e_bit; the all-zero lock-up state is replaced by SEED
  always_comb begin
    nxt     = (state >> 1) ^ (state[0] ? TAPS : '0);
    mix     = nxt ^ {e_bit, {(STATE_W-1){1'b0}}};
    state_d = (mix == '0) ? SEED : mix;
  end

  // Fold the upcoming state down to one word: low half xor zero-extended high part
  always_comb begin
    ext                = '0;
    ext[STATE_W-1:0]   = state_d;
    fold_d             = ext[WB_WIDTH-1:0] ^ ext[2*WB_WIDTH-1:WB_WIDTH];
  end

  // LFSR state advances on every edge, independent of the handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else begin
      state <= state_d;
    end
  end

  // Mix/hold sequencer with registered word and valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= MIX;
      cnt       <= '0;
      rnd_valid <= 1'b0;
      rnd_word  <= '0;
    end else begin
      unique case (fsm)
        MIX: begin
          if (cnt == CW'(MIX_CYCLES - 1)) begin
            rnd_word  <= fold_d;
            rnd_valid <= 1'b1;
            cnt       <= '0;
            fsm       <= HOLD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HOLD: begin
          if (rnd_ready) begin
            rnd_valid <= 1'b0;
            fsm       <= MIX;
          end
        end
        default: fsm <= MIX;
      endcase
    end
  end

`ifdef ENTROPY_PRNG_HEALTH_EN
  localparam int RW = $clog2(REP_LIMIT + 1);

  logic [RW-1:0] run;
  logic [RW-1:0] run_n;
  logic          prev;
  logic          fail_q;

  // Run length: restarts at 1 on the first sample or a bit change, saturates at the limit
  always_comb begin
    if (run == '0 || e_bit != prev) begin
      run_n = RW'(1);
    end else if (run == RW'(REP_LIMIT)) begin
      run_n = run;
    end else begin
      run_n = run + RW'(1);
    end
  end

  // Repetition-count tracking with a sticky alarm
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run    <= '0;
      prev   <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      run  <= run_n;
      prev <= e_bit;
      if (run_n == RW'(REP_LIMIT)) begin
        fail_q <= 1'b1;
      end
    end
  end

  assign health_fail = fail_q;
`else
  assign health_fail = 1'b0;
`endif

endmodule

// File: tb/tb_entropy_prng.sv
// tb_entropy_prng: vector table, scoreboard and corner sequences for entropy_prng.
// Three instances: default, narrow-word single-mix, and a lock-up prone tap set.
module tb_entropy_prng;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst_n, a_e, a_ready, a_valid, a_hf;
  logic [31:0] a_word;
  logic        b_rst_n, b_e, b_ready, b_valid, b_hf;
  logic [15:0] b_word;
  logic        c_rst_n, c_e, c_ready, c_valid, c_hf;
  logic [31:0] c_word;

  entropy_prng u_a (
    .clk(clk), .rst_n(a_rst_n), .e_bit(a_e), .rnd_ready(a_ready),
    .rnd_valid(a_valid), .rnd_word(a_word), .health_fail(a_hf)
  );

  entropy_prng #(.WB_WIDTH(16), .MIX_CYCLES(1)) u_b (
    .clk(clk), .rst_n(b_rst_n), .e_bit(b_e), .rnd_ready(b_ready),
    .rnd_valid(b_valid), .rnd_word(b_word), .health_fail(b_hf)
  );

  entropy_prng #(.TAPS(32'h80000000), .SEED(32'h00000003),
                 .MIX_CYCLES(2)) u_c (
    .clk(clk), .rst_n(c_rst_n), .e_bit(c_e), .rnd_ready(c_ready),
    .rnd_valid(c_valid), .rnd_word(c_word), .health_fail(c_hf)
  );

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model for u_a (default parameters)
  logic [31:0] m_state;
  bit          m_hold;
  int          m_cnt;
  bit          m_valid;
  logic [31:0] sb[$];

  function automatic logic [31:0] step(input logic [31:0] s,
                                       input logic e);
    logic [31:0] n;
    n = (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
    n = n ^ {e, 31'b0};
    return (n == 32'h0) ? 32'h00000001 : n;
  endfunction

  task automatic model_reset();
    m_state = 32'h00000001;
    m_hold  = 1'b0;
    m_cnt   = 0;
    m_valid = 1'b0;
    sb.delete();
  endtask

  // called just after a negedge; returns just after the next negedge
  task automatic a_tick(input logic e, input logic r);
    logic [31:0] ns;
    a_e     = e;
    a_ready = r;
    if (a_valid && r) begin
      if (sb.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL sb_empty: got word %h expected none", a_word);
      end else begin
        chk("a_word", a_word, sb.pop_front());
      end
    end
    @(posedge clk);
    ns = step(m_state, e);
    if (!m_hold) begin
      if (m_cnt == 3) begin
        sb.push_back(ns);
        m_valid = 1'b1;
        m_hold  = 1'b1;
        m_cnt   = 0;
      end else begin
        m_cnt++;
      end
    end else if (r) begin
      m_valid = 1'b0;
      m_hold  = 1'b0;
    end
    m_state = ns;
    #1;
    chk("a_valid", {31'b0, a_valid}, {31'b0, m_valid});
    @(negedge clk);
  endtask

  // reset pulse; mid=1 asserts it 2ns after a posedge (inside a cycle)
  task automatic a_reset(input bit mid);
    if (mid) begin
      @(posedge clk);
      #2;
    end else begin
      @(negedge clk);
    end
    a_rst_n = 1'b0;
    #1;
    chk("a_rst_valid", {31'b0, a_valid}, 32'h0);
    chk("a_rst_word", a_word, 32'h0);
    chk("a_rst_hf", {31'b0, a_hf}, 32'h0);
    @(negedge clk);
    a_rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit          rst;
    logic        e;
    logic        rdy;
    logic        exp_v;
    logic [15:0] exp_w;
  } vec_t;

  vec_t vt[9];

  initial begin
    a_rst_n = 1'b0; a_e = 1'b0; a_ready = 1'b0;
    b_rst_n = 1'b0; b_e = 1'b0; b_ready = 1'b0;
    c_rst_n = 1'b0; c_e = 1'b0; c_ready = 1'b0;
    model_reset();

    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h8023};
    vt[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h8023};
    vt[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h6019};
    vt[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h6019};
    vt[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h1834};
    vt[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h1834};
    vt[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0023};
    vt[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0023};
    vt[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0023};

    #12;
    chk("b_rst_valid", {31'b0, b_valid}, 32'h0);
    chk("b_rst_word", {16'b0, b_word}, 32'h0);

    // table: narrow word, one mix cycle per word
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (vt[i].rst) begin
        b_rst_n = 1'b0;
        #2;
        b_rst_n = 1'b1;
      end
      b_e     = vt[i].e;
      b_ready = vt[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("b_valid[%0d]", i), {31'b0, b_valid},
          {31'b0, vt[i].exp_v});
      chk($sformatf("b_word[%0d]", i), {16'b0, b_word},
          {16'b0, vt[i].exp_w});
    end

    // lock-up recovery: e_bit=1 drives state 1 into an all-zero mix
    @(negedge clk);
    c_e     = 1'b1;
    c_ready = 1'b1;
    c_rst_n = 1'b1;
    @(posedge clk); #1;
    chk("c_valid_e1", {31'b0, c_valid}, 32'h0);
    @(posedge clk); #1;
    chk("c_valid_e2", {31'b0, c_valid}, 32'h1);
    chk("c_word_seed", c_word, 32'h00000003);
    @(posedge clk); #1;
    chk("c_valid_e3", {31'b0, c_valid}, 32'h0);
    @(posedge clk);
    @(posedge clk); #1;
    chk("c_valid_e5", {31'b0, c_valid}, 32'h1);
    chk("c_word_e5", c_word, 32'h00000001);

    // default instance: first word, 20-cycle hold, single-edge ready
    a_reset(1'b0);
    for (int i = 0; i < 4; i++) a_tick(1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 20; i++) begin
      a_tick(1'($urandom_range(0, 1)), 1'b0);
      if (sb.size() != 0) chk("hold_word", a_word, sb[0]);
    end
    a_tick(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) a_tick(1'($urandom_range(0, 1)), 1'b0);

    // ready held high: one valid cycle in every five
    for (int i = 0; i < 30; i++) a_tick(1'($urandom_range(0, 1)), 1'b1);

    // random e_bit and ready
    for (int i = 0; i < 200; i++)
      a_tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // asynchronous reset while a word is held
    a_reset(1'b0);
    for (int i = 0; i < 6; i++) a_tick(1'($urandom_range(0, 1)), 1'b0);
    a_reset(1'b1);
    for (int i = 0; i < 8; i++) a_tick(1'($urandom_range(0, 1)), 1'b0);
    a_tick(1'b0, 1'b1);

    // repetition-count health alarm
    a_reset(1'b0);
    for (int i = 0; i < 31; i++) a_tick(1'b1, 1'b1);
    chk("hf_31", {31'b0, a_hf}, 32'h0);
    a_tick(1'b1, 1'b1);
`ifdef ENTROPY_PRNG_HEALTH_EN
    chk("hf_32", {31'b0, a_hf}, 32'h1);
    for (int i = 0; i < 6; i++) a_tick(1'(i % 2), 1'b1);
    chk("hf_sticky", {31'b0, a_hf}, 32'h1);
`else
    chk("hf_32", {31'b0, a_hf}, 32'h0);
    for (int i = 0; i < 10; i++) a_tick(1'b1, 1'b1);
    chk("hf_off", {31'b0, a_hf}, 32'h0);
`endif
    a_reset(1'b0);
    for (int i = 0; i < 5; i++) a_tick(1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
